// File: rtl/ysyx_23060201_mem_arbiter.sv
// Purpose : two-master (IFU read-only, LSU read/write) arbiter and sequencer for a single-port memory.
// Latency : accept in T, one memory strobe in T+LATENCY, response valid from T+LATENCY+1.
// Backpr. : one transaction outstanding; requests are refused outside IDLE and the
//           response is held stable until the owning master asserts its resp_ready.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   ifu_req_* / ifu_resp_*        IFU fetch request and response channels
//   lsu_req_* / lsu_resp_*        LSU load/store request and response channels
//   mem_r* / mem_w*               memory read/write ports; address, mask and data
//                                 come from the latched request, strobes qualify them
module ysyx_23060201_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_addr,
    output logic                  ifu_resp_valid,
    input  logic                  ifu_resp_ready,
    output logic [DATA_WIDTH-1:0] ifu_resp_data,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic                  lsu_wen,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [7:0]            lsu_mask,
    output logic                  lsu_resp_valid,
    input  logic                  lsu_resp_ready,
    output logic [DATA_WIDTH-1:0] lsu_resp_data,

    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [7:0]            mem_rmask,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [7:0]            mem_wmask,
    output logic [DATA_WIDTH-1:0] mem_wdata
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    // Instruction fetches are always full 32-bit reads.
    localparam logic [7:0] IFU_MASK = 8'h0F;

    // The counter is preloaded with LATENCY-1 so that a count of zero marks
    // the strobe cycle; LATENCY=1 therefore strobes in the first ACCESS cycle.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    // Latched request as one packed bundle; it drives the memory-side
    // address/mask/data for the whole life of the transaction.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [7:0]            mask;
        logic                  wen;
    } req_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]            state;
    logic                  owner;
    logic                  last_grant;
    logic [3:0]            cnt;
    req_t                  req_q;
    logic [DATA_WIDTH-1:0] resp_data;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic in_idle;
    logic grant_ifu;
    logic grant_lsu;

    // A lone requester always wins; on a tie the master that did not win
    // last time goes first. Ready is suppressed while reset is applied so
    // no master believes a request was taken that reset is about to drop.
    always_comb begin
        in_idle   = (state == S_IDLE) && !rst;
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (in_idle) begin
            if (ifu_req_valid && lsu_req_valid) begin
                grant_ifu = (last_grant == OWN_LSU);
                grant_lsu = (last_grant == OWN_IFU);
            end else begin
                grant_ifu = ifu_req_valid;
                grant_lsu = lsu_req_valid;
            end
        end
    end

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;

    // ------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------
    req_t ifu_req;
    req_t lsu_req;

    always_comb begin
        ifu_req       = '0;
        ifu_req.addr  = ifu_addr;
        ifu_req.mask  = IFU_MASK;
        ifu_req.wen   = 1'b0;

        lsu_req       = '0;
        lsu_req.addr  = lsu_addr;
        lsu_req.wdata = lsu_wdata;
        lsu_req.mask  = lsu_mask;
        lsu_req.wen   = lsu_wen;
    end

    // ------------------------------------------------------------------
    // Sequencing
    // ------------------------------------------------------------------
    logic strobe;        // the single memory access cycle
    logic owner_ready;   // the owning master accepts its response

    assign strobe      = (state == S_ACCESS) && (cnt == 4'd0);
    assign owner_ready = (owner == OWN_IFU) ? ifu_resp_ready : lsu_resp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            owner      <= OWN_IFU;
            last_grant <= OWN_LSU;
            cnt        <= 4'd0;
            req_q      <= '0;
            resp_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_ifu) begin
                        req_q      <= ifu_req;
                        owner      <= OWN_IFU;
                        last_grant <= OWN_IFU;
                        cnt        <= CNT_LOAD;
                        state      <= S_ACCESS;
                    end else if (grant_lsu) begin
                        req_q      <= lsu_req;
                        owner      <= OWN_LSU;
                        last_grant <= OWN_LSU;
                        cnt        <= CNT_LOAD;
                        state      <= S_ACCESS;
                    end
                end

                S_ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Read data is only valid during the strobe cycle, so
                        // it is captured at the edge that ends it. Stores
                        // complete with a zero payload.
                        resp_data <= req_q.wen ? '0 : mem_rdata;
                        state     <= S_RESP;
                    end
                end

                S_RESP: begin
                    if (owner_ready) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Memory side
    // ------------------------------------------------------------------
    assign mem_ren   = strobe && !req_q.wen;
    assign mem_wen   = strobe &&  req_q.wen;
    assign mem_raddr = req_q.addr;
    assign mem_rmask = req_q.mask;
    assign mem_waddr = req_q.addr;
    assign mem_wmask = req_q.mask;
    assign mem_wdata = req_q.wdata;

    // ------------------------------------------------------------------
    // Response side
    // ------------------------------------------------------------------
    assign ifu_resp_valid = (state == S_RESP) && (owner == OWN_IFU);
    assign lsu_resp_valid = (state == S_RESP) && (owner == OWN_LSU);
    assign ifu_resp_data  = resp_data;
    assign lsu_resp_data  = resp_data;

endmodule

// File: tb/tb_ysyx_23060201_mem_arbiter.sv
// Bench for ysyx_23060201_mem_arbiter: a LATENCY=3 instance with a word memory model
// and a LATENCY=1 instance for the single-cycle fetch timing.
module tb_ysyx_23060201_mem_arbiter;

    localparam int LAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    // main instance (LATENCY=3)
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_addr, ifu_resp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_addr, lsu_wdata, lsu_resp_data;
    logic [7:0]  lsu_mask;
    logic        mem_ren, mem_wen;
    logic [31:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
    logic [7:0]  mem_rmask, mem_wmask;

    // second instance (LATENCY=1)
    logic        s_ifu_req_valid, s_ifu_req_ready, s_ifu_resp_valid, s_ifu_resp_ready;
    logic [31:0] s_ifu_addr, s_ifu_resp_data;
    logic        s_lsu_req_valid, s_lsu_req_ready, s_lsu_wen, s_lsu_resp_valid, s_lsu_resp_ready;
    logic [31:0] s_lsu_addr, s_lsu_wdata, s_lsu_resp_data;
    logic [7:0]  s_lsu_mask;
    logic        s_mem_ren, s_mem_wen;
    logic [31:0] s_mem_raddr, s_mem_rdata, s_mem_waddr, s_mem_wdata;
    logic [7:0]  s_mem_rmask, s_mem_wmask;

    int errors = 0;
    int checks = 0;

    ysyx_23060201_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_resp_data(ifu_resp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_mask(lsu_mask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_data(lsu_resp_data),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rmask(mem_rmask), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata)
    );

    ysyx_23060201_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .ifu_req_valid(s_ifu_req_valid), .ifu_req_ready(s_ifu_req_ready), .ifu_addr(s_ifu_addr),
        .ifu_resp_valid(s_ifu_resp_valid), .ifu_resp_ready(s_ifu_resp_ready), .ifu_resp_data(s_ifu_resp_data),
        .lsu_req_valid(s_lsu_req_valid), .lsu_req_ready(s_lsu_req_ready), .lsu_wen(s_lsu_wen),
        .lsu_addr(s_lsu_addr), .lsu_wdata(s_lsu_wdata), .lsu_mask(s_lsu_mask),
        .lsu_resp_valid(s_lsu_resp_valid), .lsu_resp_ready(s_lsu_resp_ready), .lsu_resp_data(s_lsu_resp_data),
        .mem_ren(s_mem_ren), .mem_raddr(s_mem_raddr), .mem_rmask(s_mem_rmask), .mem_rdata(s_mem_rdata),
        .mem_wen(s_mem_wen), .mem_waddr(s_mem_waddr), .mem_wmask(s_mem_wmask), .mem_wdata(s_mem_wdata)
    );

    // ---------------- memory models ----------------
    logic [31:0] mem [0:4095];
    logic        mem_clear;
    int          wcnt = 0;

    assign mem_rdata   = mem_ren ? mem[mem_raddr[13:2]] : 32'h0BAD_0BAD;
    assign s_mem_rdata = (s_mem_raddr == 32'h8000_0000) ? 32'h0000_0013 : 32'h0;

    always @(negedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
            mem[12'h000] = 32'h0000_0013;   // word at 0x80000000
        end else if (mem_wen) begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) mem[mem_waddr[13:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            wcnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; mem_clear = 1'b1;
        ifu_req_valid = 0; ifu_addr = 0; ifu_resp_ready = 1;
        lsu_req_valid = 0; lsu_wen = 0; lsu_addr = 0; lsu_wdata = 0; lsu_mask = 0; lsu_resp_ready = 1;
        s_ifu_req_valid = 0; s_ifu_addr = 0; s_ifu_resp_ready = 1;
        s_lsu_req_valid = 0; s_lsu_wen = 0; s_lsu_addr = 0; s_lsu_wdata = 0; s_lsu_mask = 0; s_lsu_resp_ready = 1;
        step(); step();
        checks++; if (ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_ifu_resp_valid: got %b want 0", ifu_resp_valid); end
        checks++; if (lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_lsu_resp_valid: got %b want 0", lsu_resp_valid); end
        checks++; if (mem_ren !== 1'b0 || mem_wen !== 1'b0) begin errors++; $display("FAIL reset_strobes: got ren=%b wen=%b want 0 0", mem_ren, mem_wen); end
        checks++; if (mem_raddr !== 32'h0 || mem_waddr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h/%h want 0", mem_raddr, mem_waddr); end
        checks++; if (mem_wdata !== 32'h0 || mem_wmask !== 8'h0 || mem_rmask !== 8'h0) begin errors++; $display("FAIL reset_wdata_mask: got %h %h %h want 0", mem_wdata, mem_wmask, mem_rmask); end
        checks++; if (ifu_resp_data !== 32'h0 || lsu_resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h/%h want 0", ifu_resp_data, lsu_resp_data); end
        checks++; if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_no_valid: got %b/%b want 0 0", ifu_req_ready, lsu_req_ready); end
        rst = 1'b0; mem_clear = 1'b0;
        step();
    endtask

    task automatic test_ifu_read_lat1();
        s_ifu_addr = 32'h8000_0000; s_ifu_req_valid = 1'b1;
        #1;
        checks++; if (s_ifu_req_ready !== 1'b1) begin errors++; $display("FAIL l1_ready_T: got %b want 1", s_ifu_req_ready); end
        step();                                      // T+1
        s_ifu_req_valid = 1'b0;
        checks++; if (s_mem_ren !== 1'b1 || s_mem_wen !== 1'b0) begin errors++; $display("FAIL l1_strobe_T1: got ren=%b wen=%b want 1 0", s_mem_ren, s_mem_wen); end
        checks++; if (s_mem_raddr !== 32'h8000_0000 || s_mem_rmask !== 8'h0F) begin errors++; $display("FAIL l1_raddr_rmask: got %h %h want 80000000 0f", s_mem_raddr, s_mem_rmask); end
        checks++; if (s_ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL l1_early_resp: got %b want 0", s_ifu_resp_valid); end
        step();                                      // T+2
        checks++; if (s_mem_ren !== 1'b0) begin errors++; $display("FAIL l1_ren_T2: got %b want 0", s_mem_ren); end
        checks++; if (s_ifu_resp_valid !== 1'b1 || s_ifu_resp_data !== 32'h0000_0013) begin errors++; $display("FAIL l1_resp_T2: got v=%b d=%h want 1 00000013", s_ifu_resp_valid, s_ifu_resp_data); end
        checks++; if (s_lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL l1_lsu_resp: got %b want 0", s_lsu_resp_valid); end
        step();                                      // T+3
        checks++; if (s_ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL l1_resp_done: got %b want 0", s_ifu_resp_valid); end
    endtask

    task automatic test_store_load();
        int st_at, st_cyc, rs_at, ifu_rv, w0, rd_at, rd_cyc;
        logic [31:0] got, wa, wd, ra;
        logic [7:0]  wm, rm;
        // store
        w0 = wcnt; st_at = -1; st_cyc = 0; rs_at = -1; ifu_rv = 0; got = 32'hx; wa = 0; wd = 0; wm = 0;
        lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF; lsu_mask = 8'h0F;
        #1;
        checks++; if (lsu_req_ready !== 1'b1) begin errors++; $display("FAIL st_ready: got %b want 1", lsu_req_ready); end
        for (int k = 1; k <= LAT + 2; k++) begin
            step();
            if (k == 1) lsu_req_valid = 0;
            if (mem_ren) ifu_rv++;
            if (mem_wen) begin st_cyc++; if (st_at < 0) begin st_at = k; wa = mem_waddr; wd = mem_wdata; wm = mem_wmask; end end
            if (ifu_resp_valid) ifu_rv++;
            if (lsu_resp_valid && rs_at < 0) begin rs_at = k; got = lsu_resp_data; end
        end
        checks++; if (st_cyc !== 1 || st_at !== LAT) begin errors++; $display("FAIL st_wen_pulse: got %0d cycles at T+%0d want 1 at T+%0d", st_cyc, st_at, LAT); end
        checks++; if (wa !== 32'h8000_1000 || wd !== 32'hDEAD_BEEF || wm !== 8'h0F) begin errors++; $display("FAIL st_wport: got %h %h %h want 80001000 deadbeef 0f", wa, wd, wm); end
        checks++; if (rs_at !== LAT + 1 || got !== 32'h0) begin errors++; $display("FAIL st_resp: got T+%0d data %h want T+%0d data 0", rs_at, got, LAT + 1); end
        checks++; if (ifu_rv !== 0) begin errors++; $display("FAIL st_no_ifu_or_ren: got %0d want 0", ifu_rv); end
        checks++; if (wcnt - w0 !== 1 || mem[12'h400] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_mem: got %0d writes word %h want 1 deadbeef", wcnt - w0, mem[12'h400]); end
        checks++; if (lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL st_resp_done: got %b want 0", lsu_resp_valid); end
        // load
        rd_at = -1; rd_cyc = 0; rs_at = -1; got = 32'hx; ra = 0; rm = 0;
        lsu_req_valid = 1; lsu_wen = 0; lsu_wdata = 0;
        #1;
        checks++; if (lsu_req_ready !== 1'b1) begin errors++; $display("FAIL ld_ready: got %b want 1", lsu_req_ready); end
        for (int k = 1; k <= LAT + 2; k++) begin
            step();
            if (k == 1) lsu_req_valid = 0;
            if (mem_ren) begin rd_cyc++; if (rd_at < 0) begin rd_at = k; ra = mem_raddr; rm = mem_rmask; end end
            if (lsu_resp_valid && rs_at < 0) begin rs_at = k; got = lsu_resp_data; end
        end
        checks++; if (rd_cyc !== 1 || rd_at !== LAT || ra !== 32'h8000_1000 || rm !== 8'h0F) begin errors++; $display("FAIL ld_ren: got %0d cycles at T+%0d addr %h mask %h", rd_cyc, rd_at, ra, rm); end
        checks++; if (rs_at !== LAT + 1 || got !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_resp: got T+%0d data %h want T+%0d deadbeef", rs_at, got, LAT + 1); end
    endtask

    task automatic test_backpressure();
        int viol, seen;
        logic [31:0] held;
        viol = 0; seen = 0;
        lsu_resp_ready = 0;
        lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_1000; lsu_mask = 8'h0F;
        #1;
        checks++; if (lsu_req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready: got %b want 1", lsu_req_ready); end
        step();
        lsu_req_valid = 0; ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        for (int n = 0; n < 10 && !lsu_resp_valid; n++) begin
            #1; if (ifu_req_ready) viol++;
            step();
        end
        checks++; if (lsu_resp_valid !== 1'b1) begin errors++; $display("FAIL bp_resp_timeout: got %b want 1", lsu_resp_valid); end
        held = lsu_resp_data;
        checks++; if (held !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bp_data: got %h want deadbeef", held); end
        for (int n = 0; n < 4; n++) begin
            step();
            if (!lsu_resp_valid || lsu_resp_data !== held || ifu_req_ready || lsu_req_ready || mem_ren || mem_wen || ifu_resp_valid) viol++;
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL bp_hold: got %0d violations want 0", viol); end
        lsu_resp_ready = 1;
        step();
        checks++; if (lsu_resp_valid !== 1'b0 || ifu_req_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got resp_v=%b ifu_rdy=%b want 0 1", lsu_resp_valid, ifu_req_ready); end
        step();
        ifu_req_valid = 0;
        held = 32'hx;
        for (int n = 0; n < 5; n++) begin
            step();
            if (ifu_resp_valid) begin seen++; held = ifu_resp_data; end
        end
        checks++; if (seen !== 1 || held !== 32'h0000_0013) begin errors++; $display("FAIL bp_ifu_after: got %0d resp data %h want 1 00000013", seen, held); end
    endtask

    task automatic test_back_to_back_tie();
        int order[3];
        int gcyc[3];
        int ng, viol;
        ng = 0; viol = 0;
        for (int i = 0; i < 3; i++) begin order[i] = -1; gcyc[i] = -1; end
        rst = 1;
        step();
        rst = 0;
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_1000; lsu_mask = 8'h0F;
        #1;
        for (int c = 0; c < 40 && ng < 3; c++) begin
            if (ifu_req_ready && lsu_req_ready) viol++;
            if ((ifu_req_ready || lsu_req_ready) && (ifu_resp_valid || lsu_resp_valid || mem_ren || mem_wen)) viol++;
            if (ifu_req_ready) begin order[ng] = 0; gcyc[ng] = c; ng++; end
            else if (lsu_req_ready) begin order[ng] = 1; gcyc[ng] = c; ng++; end
            step();
        end
        ifu_req_valid = 0; lsu_req_valid = 0;
        for (int n = 0; n < LAT + 3; n++) begin
            step();
            if (ifu_req_ready || lsu_req_ready) viol++;
        end
        checks++; if (ng !== 3) begin errors++; $display("FAIL tie_grants: got %0d want 3", ng); end
        checks++; if (order[0] !== 0 || order[1] !== 1 || order[2] !== 0) begin errors++; $display("FAIL tie_order: got %0d %0d %0d want 0 1 0 (0=IFU)", order[0], order[1], order[2]); end
        checks++; if (gcyc[0] !== 0) begin errors++; $display("FAIL tie_first_cycle: got %0d want 0", gcyc[0]); end
        checks++; if (gcyc[1] - gcyc[0] !== LAT + 2 || gcyc[2] - gcyc[1] !== LAT + 2) begin errors++; $display("FAIL tie_interval: got %0d %0d want %0d", gcyc[1] - gcyc[0], gcyc[2] - gcyc[1], LAT + 2); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL tie_ready_outside_idle: got %0d violations want 0", viol); end
    endtask

    task automatic test_reset_access();
        int viol, w0;
        viol = 0; w0 = wcnt;
        lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_0000; lsu_wdata = 32'h1234_5678; lsu_mask = 8'h0F;
        #1;
        checks++; if (lsu_req_ready !== 1'b1) begin errors++; $display("FAIL rsta_ready: got %b want 1", lsu_req_ready); end
        step();                 // T+1
        lsu_req_valid = 0;
        step();                 // T+2
        rst = 1;
        step();                 // T+3
        rst = 0;
        checks++; if (mem_wen !== 1'b0 || lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL rsta_idle: got wen=%b resp=%b want 0 0", mem_wen, lsu_resp_valid); end
        checks++; if (mem_waddr !== 32'h0 || mem_wmask !== 8'h0) begin errors++; $display("FAIL rsta_cleared: got %h %h want 0 0", mem_waddr, mem_wmask); end
        for (int n = 0; n < 6; n++) begin
            step();
            if (mem_wen || mem_ren || lsu_resp_valid || ifu_resp_valid) viol++;
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL rsta_quiet: got %0d violations want 0", viol); end
        checks++; if (wcnt !== w0 || mem[12'h000] !== 32'h0000_0013) begin errors++; $display("FAIL rsta_no_write: got %0d writes word %h want 0 00000013", wcnt - w0, mem[12'h000]); end
        ifu_req_valid = 1; lsu_req_valid = 1; lsu_wen = 0;
        #1;
        checks++; if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin errors++; $display("FAIL rsta_tie: got ifu=%b lsu=%b want 1 0", ifu_req_ready, lsu_req_ready); end
        ifu_req_valid = 0; lsu_req_valid = 0;
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ifu_read_lat1();
        test_store_load();
        test_backpressure();
        test_back_to_back_tie();
        test_reset_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
